// File: rtl/hazard_stall_scheduler_if.sv
// ============================================================================
// Module  : hazard_stall_scheduler_if
// Brief   : Hazard inputs and stall/bubble/divider controls between pipeline and scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hazard_stall_scheduler_if #(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
);
   logic [ADDR_W-1:0] reg_data_1_addr_ID;
   logic [ADDR_W-1:0] reg_data_2_addr_ID;
   logic              re_1_ID;
   logic              re_2_ID;
   logic              is_branch_ID;
   logic [ADDR_W-1:0] target_EX;
   logic              WriteReg_EX;
   logic              MemOrAlu_EX;
   logic              div_req_EX;
   logic              mem_wait_MEM;

   logic              stall_PC;
   logic              stall_IF_ID;
   logic              stall_ID_EX;
   logic              stall_EX_MEM;
   logic              bubble_EX;
   logic              bubble_MEM;
   logic              bubble_WB;
   logic              div_start;
   logic              div_done;
   logic              div_busy;
   logic [CNT_W-1:0]  stall_count;

   modport master (
      output reg_data_1_addr_ID, reg_data_2_addr_ID, re_1_ID, re_2_ID, is_branch_ID,
             target_EX, WriteReg_EX, MemOrAlu_EX, div_req_EX, mem_wait_MEM,
      input  stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, bubble_EX, bubble_MEM,
             bubble_WB, div_start, div_done, div_busy, stall_count
   );

   modport slave (
      input  reg_data_1_addr_ID, reg_data_2_addr_ID, re_1_ID, re_2_ID, is_branch_ID,
             target_EX, WriteReg_EX, MemOrAlu_EX, div_req_EX, mem_wait_MEM,
      output stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, bubble_EX, bubble_MEM,
             bubble_WB, div_start, div_done, div_busy, stall_count
   );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_scheduler.sv
// ============================================================================
// Module  : hazard_stall_scheduler
// Brief   : Load-use/branch stall, divider sequencing, memory-wait stall and stall counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_stall_scheduler #(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 32
) (
   input wire logic               clk,
   input wire logic               rst,
   hazard_stall_scheduler_if.slave bus
);
   localparam logic c_MEM = 1'b1;
   localparam int   c_CW  = $clog2(DIV_CYCLES) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [c_CW-1:0]   r_div_cnt;
   logic [c_CW-1:0]   w_div_cnt_nxt;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_src_match;
   logic w_lu;
   logic w_br;
   logic w_start_raw;
   logic w_done_raw;
   logic w_stall_pc, w_stall_if_id, w_stall_id_ex, w_stall_ex_mem;
   logic w_bubble_ex, w_bubble_mem, w_bubble_wb;

   // A load producer on a branch is already caught by LU, so BR only covers ALU producers.
   always_comb begin
      w_src_match = bus.WriteReg_EX && (bus.target_EX != '0) &&
                    ((bus.re_1_ID && (bus.reg_data_1_addr_ID == bus.target_EX)) ||
                     (bus.re_2_ID && (bus.reg_data_2_addr_ID == bus.target_EX)));
      w_lu = w_src_match && (bus.MemOrAlu_EX == c_MEM);
      w_br = w_src_match && bus.is_branch_ID && (bus.MemOrAlu_EX != c_MEM);
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_div_cnt_nxt = r_div_cnt;
      w_start_raw   = 1'b0;
      w_done_raw    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.div_req_EX && !bus.mem_wait_MEM) begin
               w_start_raw   = 1'b1;
               w_div_cnt_nxt = c_CW'(DIV_CYCLES - 1);
               w_state_nxt   = S_BUSY;
            end
         end
         S_BUSY: begin
            w_div_cnt_nxt = r_div_cnt - c_CW'(1);
            if (r_div_cnt == c_CW'(1)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            // Result is held valid until the memory wait lets EX actually consume it.
            w_done_raw = 1'b1;
            if (!bus.mem_wait_MEM) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_stall_pc     = 1'b0;
      w_stall_if_id  = 1'b0;
      w_stall_id_ex  = 1'b0;
      w_stall_ex_mem = 1'b0;
      w_bubble_ex    = 1'b0;
      w_bubble_mem   = 1'b0;
      w_bubble_wb    = 1'b0;
      if (rst) begin
         if (bus.mem_wait_MEM) begin
            w_stall_pc     = 1'b1;
            w_stall_if_id  = 1'b1;
            w_stall_id_ex  = 1'b1;
            w_stall_ex_mem = 1'b1;
            w_bubble_wb    = 1'b1;
         end else if ((r_state == S_BUSY) || w_start_raw) begin
            w_stall_pc    = 1'b1;
            w_stall_if_id = 1'b1;
            w_stall_id_ex = 1'b1;
            w_bubble_mem  = 1'b1;
         end else if (w_lu || w_br) begin
            w_stall_pc    = 1'b1;
            w_stall_if_id = 1'b1;
            w_bubble_ex   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_div_cnt   <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_div_cnt <= w_div_cnt_nxt;
         if (w_stall_pc && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.stall_PC     = w_stall_pc;
   assign bus.stall_IF_ID  = w_stall_if_id;
   assign bus.stall_ID_EX  = w_stall_id_ex;
   assign bus.stall_EX_MEM = w_stall_ex_mem;
   assign bus.bubble_EX    = w_bubble_ex;
   assign bus.bubble_MEM   = w_bubble_mem;
   assign bus.bubble_WB    = w_bubble_wb;
   assign bus.div_start    = rst && w_start_raw;
   assign bus.div_done     = rst && w_done_raw;
   assign bus.div_busy     = rst && (r_state != S_IDLE);
   assign bus.stall_count  = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_scheduler.sv
// ============================================================================
// Module  : tb_hazard_stall_scheduler
// Brief   : Directed scoreboard bench for hazard_stall_scheduler (DIV_CYCLES=4, CNT_W=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_stall_scheduler;
   localparam int c_DIV = 4;
   localparam int c_CW  = 4;

   // Bit order: PC, IF_ID, ID_EX, EX_MEM, bEX, bMEM, bWB, start, done, busy
   localparam logic [9:0] c_NONE = 10'b0000000000;
   localparam logic [9:0] c_LU   = 10'b1100100000;
   localparam logic [9:0] c_DST  = 10'b1110010100;
   localparam logic [9:0] c_BSY  = 10'b1110010001;
   localparam logic [9:0] c_DON  = 10'b0000000011;
   localparam logic [9:0] c_MW   = 10'b1111001000;
   localparam logic [9:0] c_MWB  = 10'b1111001001;
   localparam logic [9:0] c_MWD  = 10'b1111001011;

   typedef struct packed {
      logic [9:0]      vec;
      logic [c_CW-1:0] cnt;
      logic            chk;
   } exp_t;

   logic clk;
   logic rst;
   exp_t q[$];
   exp_t r_e;
   logic [9:0] r_got;
   logic [c_CW-1:0] exp_cnt;
   int n_checks;
   int n_err;
   int n_step;

   hazard_stall_scheduler_if #(.ADDR_W(5), .CNT_W(c_CW)) bus ();

   hazard_stall_scheduler #(.DIV_CYCLES(c_DIV), .CNT_W(c_CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
      $fatal(1);
   end

   always @(negedge clk) begin
      if (q.size() > 0) begin
         r_e   = q.pop_front();
         r_got = {bus.stall_PC, bus.stall_IF_ID, bus.stall_ID_EX, bus.stall_EX_MEM,
                  bus.bubble_EX, bus.bubble_MEM, bus.bubble_WB,
                  bus.div_start, bus.div_done, bus.div_busy};
         n_checks++;
         if (r_got !== r_e.vec) begin
            n_err++;
            $display("FAIL ctl step=%0d got=%b want=%b", n_step, r_got, r_e.vec);
         end
         if (r_e.chk) begin
            n_checks++;
            if (bus.stall_count !== r_e.cnt) begin
               n_err++;
               $display("FAIL stall_count step=%0d got=%0d want=%0d", n_step, bus.stall_count, r_e.cnt);
            end
         end
         n_step++;
      end
   end

   task automatic step(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic re1, input logic re2, input logic br,
                       input logic [4:0] tgt, input logic wr, input logic ld,
                       input logic dv, input logic mw, input logic [9:0] v);
      exp_t e;
      @(posedge clk);
      #1;
      rst                    = r;
      bus.reg_data_1_addr_ID = a1;
      bus.reg_data_2_addr_ID = a2;
      bus.re_1_ID            = re1;
      bus.re_2_ID            = re2;
      bus.is_branch_ID       = br;
      bus.target_EX          = tgt;
      bus.WriteReg_EX        = wr;
      bus.MemOrAlu_EX        = ld;
      bus.div_req_EX         = dv;
      bus.mem_wait_MEM       = mw;
      e.vec = v;
      e.cnt = exp_cnt;
      e.chk = r;
      q.push_back(e);
      if (!r) exp_cnt = '0;
      else if (v[9] && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
   endtask

   task automatic do_reset();
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_NONE);
   endtask

   task automatic idle(input logic [9:0] v);
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, v);
   endtask

   // lw $3 in EX, add $4,$3,$1 in ID
   task automatic lu(input logic mw, input logic [9:0] v);
      step(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, mw, v);
   endtask

   task automatic dv(input logic mw, input logic [9:0] v);
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, mw, v);
   endtask

   initial begin
      rst = 1'b0;
      exp_cnt = '0;
      n_checks = 0;
      n_err = 0;
      n_step = 0;
      bus.reg_data_1_addr_ID = '0;
      bus.reg_data_2_addr_ID = '0;
      bus.re_1_ID = 1'b0;
      bus.re_2_ID = 1'b0;
      bus.is_branch_ID = 1'b0;
      bus.target_EX = '0;
      bus.WriteReg_EX = 1'b0;
      bus.MemOrAlu_EX = 1'b0;
      bus.div_req_EX = 1'b0;
      bus.mem_wait_MEM = 1'b0;

      // Reset state, then load-use for one cycle
      do_reset();
      idle(c_NONE);
      lu(1'b0, c_LU);
      step(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_NONE);
      idle(c_NONE);

      // r0 and unread sources never stall; source-2 match does
      step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, c_NONE);
      step(1'b1, 5'd7, 5'd2, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, c_NONE);
      step(1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, c_NONE);
      step(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, c_LU);
      step(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, c_NONE);

      // Divider: start, 3 busy, done with DIV still in EX, back-to-back second DIV
      do_reset();
      dv(1'b0, c_DST);
      dv(1'b0, c_BSY);
      dv(1'b0, c_BSY);
      dv(1'b0, c_BSY);
      dv(1'b0, c_DON);
      dv(1'b0, c_DST);
      dv(1'b0, c_BSY);
      dv(1'b0, c_BSY);
      dv(1'b0, c_BSY);
      dv(1'b0, c_DON);
      idle(c_NONE);
      idle(c_NONE);

      // mem_wait over a load-use, then the LU stall
      do_reset();
      lu(1'b1, c_MW);
      lu(1'b1, c_MW);
      lu(1'b1, c_MW);
      lu(1'b0, c_LU);
      idle(c_NONE);

      // mem_wait blocks div start, overlaps the DONE entry and holds div_done
      do_reset();
      dv(1'b1, c_MW);
      dv(1'b0, c_DST);
      dv(1'b0, c_BSY);
      dv(1'b0, c_BSY);
      dv(1'b1, c_MWB);
      dv(1'b1, c_MWD);
      dv(1'b0, c_DON);
      idle(c_NONE);

      // Reset while BUSY with counter at 2: no div_done afterwards
      do_reset();
      dv(1'b0, c_DST);
      dv(1'b0, c_BSY);
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, c_NONE);
      idle(c_NONE);
      idle(c_NONE);
      idle(c_NONE);
      idle(c_NONE);

      // Branch on ALU producer in EX stalls; producer moved on, or non-branch, does not
      step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, c_LU);
      step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_NONE);
      step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, c_NONE);
      step(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, c_LU);
      step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, c_NONE);

      // Counter saturates at all-ones
      do_reset();
      for (int i = 0; i < 18; i++) begin
         step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, c_MW);
      end
      idle(c_NONE);
      idle(c_NONE);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         n_checks++;
         n_err++;
         $display("FAIL drain: pending=%0d want=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
